// File: rtl/uart_cmd_regfile_pkg.sv
// uart_cmd_regfile_pkg
// Shared constants for the UART command decoder / register file:
//   - protocol opcodes (write 'W', read 'R')
//   - response bytes (ack 'K', nak '?')
//   - 3-bit state encoding used by the parser and the transmit sender
package uart_cmd_regfile_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    localparam logic [7:0] RSP_ACK  = 8'h4B;
    localparam logic [7:0] RSP_NAK  = 8'h3F;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_GET_ADDR  = 3'd1;
    localparam logic [2:0] ST_GET_DATA  = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd4;
    localparam logic [2:0] ST_WAIT_DONE = 3'd5;

endpackage

// File: rtl/uart_cmd_regfile_sender.sv
// uart_tx_sender
// Hands one response byte to uart_tx and follows its busy handshake.
// Ports:
//   clk        system clock
//   resetn     asynchronous active-low reset
//   req_i      one-cycle request; byte_i is captured in the same cycle
//   byte_i     response byte
//   tx_busy_i  uart_tx busy
//   tx_data_o  byte presented to uart_tx; held until the next request
//   tx_en_o    one-cycle transmit strobe
//   done_o     high in the cycle the sender returns to idle
module uart_tx_sender
    import uart_cmd_regfile_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_i,
    input  logic [7:0] byte_i,
    input  logic       tx_busy_i,
    output logic [7:0] tx_data_o,
    output logic       tx_en_o,
    output logic       done_o
);

    logic [2:0] state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       en_q, en_d;
    logic       ack_cnt_q, ack_cnt_d;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        en_d      = 1'b0;
        ack_cnt_d = ack_cnt_q;
        done_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    data_d  = byte_i;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!tx_busy_i) begin
                    en_d      = 1'b1;
                    ack_cnt_d = 1'b0;
                    state_d   = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // Give uart_tx two cycles to acknowledge; otherwise assume it missed us.
                if (tx_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (ack_cnt_q) begin
                    state_d = ST_IDLE;
                    done_o  = 1'b1;
                end else begin
                    ack_cnt_d = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    state_d = ST_IDLE;
                    done_o  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            data_q    <= 8'h00;
            en_q      <= 1'b0;
            ack_cnt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            en_q      <= en_d;
            ack_cnt_q <= ack_cnt_d;
        end
    end

    assign tx_data_o = data_q;
    assign tx_en_o   = en_q;

endmodule

// File: rtl/uart_cmd_regfile.sv
// uart_cmd_regfile
// Byte-stream command decoder and NREGS x WORDSZ register file between uart_rx and uart_tx.
// Commands: 'W' addr data -> 'K' (or '?'), 'R' addr -> reg value (or '?').
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
// Ports:
//   clk, resetn         100 MHz clock, asynchronous active-low reset
//   rx_data, rx_valid   received byte and its one-cycle strobe
//   rx_break            BREAK from uart_rx; aborts a partial command
//   tx_data, tx_en      response byte and one-cycle transmit strobe
//   tx_busy             uart_tx busy
//   regs_flat           register file, reg i at [i*WORDSZ +: WORDSZ]
//   cmd_err             sticky error flag, cleared only by reset
module uart_cmd_regfile
    import uart_cmd_regfile_pkg::*;
#(
    parameter int unsigned WORDSZ      = 8,
    parameter int unsigned NREGS       = 4,
    parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    input  logic                      rx_break,
    output logic [7:0]                tx_data,
    output logic                      tx_en,
    input  logic                      tx_busy,
    output logic [NREGS*WORDSZ-1:0]   regs_flat,
    output logic                      cmd_err
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [2:0]        state_q, state_d;
    logic              is_write_q, is_write_d;
    logic [7:0]        addr_q, addr_d;
    logic              err_q, err_d;
    logic [WORDSZ-1:0] regs_q [NREGS];

    logic              req;
    logic [7:0]        rsp;
    logic              we;
    logic              done;
    logic              timeout;
    logic              in_cmd;

    assign in_cmd = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);

`ifdef UART_CMD_TIMEOUT_EN
    logic [26:0] tmo_q, tmo_d;

    // Entry to GET_ADDR always coincides with rx_valid, so clearing on rx_valid covers it.
    always_comb begin
        tmo_d = 27'd0;
        if (!rx_valid && in_cmd) begin
            tmo_d = tmo_q + 27'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_q <= 27'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    // A byte in the expiry cycle takes precedence.
    assign timeout = in_cmd && !rx_valid && (tmo_q == 27'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        err_d      = err_q;
        req        = 1'b0;
        rsp        = RSP_NAK;
        we         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A byte coinciding with a break is discarded.
                if (rx_valid && !rx_break) begin
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        is_write_d = (rx_data == OP_WRITE);
                        state_d    = ST_GET_ADDR;
                    end else begin
                        req     = 1'b1;
                        err_d   = 1'b1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (rx_break) begin
                    state_d = ST_IDLE;
                end else if (rx_valid) begin
                    if (is_write_q) begin
                        addr_d  = rx_data;
                        state_d = ST_GET_DATA;
                    end else begin
                        req     = 1'b1;
                        state_d = ST_SEND;
                        if (rx_data < 8'(NREGS)) begin
                            rsp = regs_q[rx_data[AW-1:0]];
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (rx_break) begin
                    state_d = ST_IDLE;
                end else if (rx_valid) begin
                    req     = 1'b1;
                    state_d = ST_SEND;
                    if (addr_q < 8'(NREGS)) begin
                        we  = 1'b1;
                        rsp = RSP_ACK;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                // Response in flight: no buffering, incoming bytes are lost.
                if (rx_valid) begin
                    err_d = 1'b1;
                end
                if (done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            is_write_q <= 1'b0;
            addr_q     <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[addr_q[AW-1:0]] <= rx_data;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[g*WORDSZ +: WORDSZ] = regs_q[g];
    end

    assign cmd_err = err_q;

    uart_tx_sender u_sender (
        .clk       (clk),
        .resetn    (resetn),
        .req_i     (req),
        .byte_i    (rsp),
        .tx_busy_i (tx_busy),
        .tx_data_o (tx_data),
        .tx_en_o   (tx_en),
        .done_o    (done)
    );

endmodule

// File: doc/uart_cmd_regfile.md
Name: uart_cmd_regfile

Overview:
- Byte-stream command decoder and register file, directly downstream of the UART receiver (uart_rx).
- Consumes rx_data/rx_valid, executes write/read commands on NREGS x WORDSZ registers, and drives the UART transmitter (uart_tx) with one response byte per command.
- The register contents drive the LED/dimmer logic and other consumers in place of the raw last-byte latch.

Parameters:
- WORDSZ, 8, register width in bits; must equal the UART payload width (8).
- NREGS, 4, number of registers; power of 2, range 2..16; AW = clog2(NREGS).
- TIMEOUT_CYC, 100_000_000, idle clocks between bytes of one command before abort (1 s at 100 MHz).

Ports:
- clk, in, 1, system clock, 100 MHz.
- resetn, in, 1, reset; asynchronous assert, active-low.
- rx_data, in, 8, received byte from uart_rx.
- rx_valid, in, 1, single-cycle strobe; rx_data is valid in the same cycle.
- rx_break, in, 1, BREAK detected by uart_rx.
- tx_data, out, 8, response byte to uart_tx.
- tx_en, out, 1, single-cycle transmit strobe.
- tx_busy, in, 1, uart_tx busy.
- regs_flat, out, NREGS*WORDSZ, register file; reg i occupies bits [i*WORDSZ +: WORDSZ].
- cmd_err, out, 1, sticky flag: bad opcode, bad address, dropped byte or timeout; cleared only by reset.

Behaviour:
- Reset value of every output and register is 0. The state machine resets to IDLE.
- Protocol:
  - Write: 'W' (0x57), addr, data.
  - Read: 'R' (0x52), addr.
  - addr is a raw binary byte.
- States: IDLE, GET_ADDR, GET_DATA, SEND, WAIT_ACK, WAIT_DONE.
- IDLE:
  - rx_valid with 'W' or 'R' -> GET_ADDR; latch the opcode.
  - Any other byte -> SEND with tx_data = '?' (0x3F), cmd_err = 1.
- GET_ADDR, on rx_valid:
  - Write -> GET_DATA; latch addr.
  - Read with addr < NREGS -> SEND with tx_data = reg[addr].
  - Read with addr >= NREGS -> SEND with '?', cmd_err = 1.
- GET_DATA, on rx_valid:
  - addr < NREGS -> reg[addr] = rx_data on this edge; regs_flat updates the next cycle; SEND with 'K' (0x4B).
  - addr >= NREGS -> data discarded; SEND with '?', cmd_err = 1.
- SEND:
  - While tx_busy = 1, hold.
  - When tx_busy = 0, assert tx_en for exactly 1 cycle with tx_data stable -> WAIT_ACK.
- WAIT_ACK: wait up to 2 cycles for tx_busy = 1 -> WAIT_DONE. If tx_busy is not seen after 2 cycles -> IDLE.
- WAIT_DONE: tx_busy = 0 -> IDLE.
- tx_data holds its value from SEND entry until the next SEND.
- Latency: the response tx_en is asserted 2 clocks after the last command byte's rx_valid, provided tx_busy = 0.
- Bytes arriving in SEND, WAIT_ACK or WAIT_DONE are dropped and set cmd_err. They are not queued (no buffering).
- rx_break:
  - In GET_ADDR or GET_DATA -> IDLE, no response, registers unchanged.
  - In SEND, WAIT_ACK or WAIT_DONE -> ignored; the transmission completes.
- Simultaneous rx_break and rx_valid: break wins and the byte is discarded.
- Reset mid-command: immediate return to IDLE; all registers cleared; tx_en low.
- Register writes are the only path that modifies regs_flat. Reads have no side effects.

Optional Feature:
- Macro: UART_CMD_TIMEOUT_EN.
- With the macro defined:
  - A 27-bit counter clears on every rx_valid and on entry to GET_ADDR, and increments in GET_ADDR and GET_DATA.
  - On reaching TIMEOUT_CYC-1 -> IDLE, cmd_err = 1, no response, registers unchanged.
  - Reaching TIMEOUT_CYC-1 in the same cycle as rx_valid: the byte wins.
- Without the macro: no counter; the parser waits indefinitely in GET_ADDR and GET_DATA.

Decomposition:
- Shared package/include holds:
  - Opcode constants OP_WRITE = 8'h57, OP_READ = 8'h52.
  - Response constants RSP_ACK = 8'h4B, RSP_NAK = 8'h3F.
  - The state encoding (3-bit localparams).
- One natural sub-module, uart_tx_sender: owns SEND/WAIT_ACK/WAIT_DONE, the tx_en pulse and the tx_busy handshake. It exposes a req/byte/done interface to the parser.

Test Plan:
- Write then read: bytes 0x57,0x02,0xA5 -> reg2 = 0xA5, regs_flat[23:16] = 0xA5, one tx_en with tx_data = 0x4B. Then 0x52,0x02 -> tx_data = 0xA5. cmd_err stays 0.
- Bad opcode and bad address:
  - 0x41 -> tx_data = 0x3F, cmd_err = 1.
  - After reset, 0x52,0x07 with NREGS = 4 -> 0x3F.
  - After reset, 0x57,0x09,0x11 -> 0x3F; all registers remain 0.
- Busy backpressure: hold tx_busy = 1 for 500 cycles around command completion -> tx_en is asserted only after tx_busy falls, exactly once. A byte received meanwhile sets cmd_err and is dropped.
- Break abort: 0x57,0x01, then rx_break -> no tx_en. A following 0x52,0x01 returns 0x00.
- Reset mid-command: write reg1 = 0x3C, then 0x57,0x01, resetn low for 3 cycles -> regs_flat = 0, IDLE, tx_en = 0. A subsequent read of reg1 returns 0x00.
- With UART_CMD_TIMEOUT_EN and TIMEOUT_CYC = 100: 0x57, then 100 idle clocks -> IDLE, cmd_err = 1, no tx_en. Repeat with a byte at clock 99 -> the command continues.
